// File: rtl/bcd_seq_decoder.sv
// rtl/bcd_seq_decoder.sv - sequential packed-BCD to signed two's-complement converter
//
// Accepts a DIGITS-digit packed BCD word plus a sign bit over a valid/ready
// handshake and folds in one digit per clock, most significant digit first,
// then applies the sign in a single negation step.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   source presents sign/bcd_in
//   in_ready   block can accept an input (IDLE only)
//   sign       1 = negative
//   bcd_in     packed digits, units digit in bcd_in[3:0]
//   out_valid  result available
//   out_ready  sink accepts the result
//   bin_out    signed two's-complement result (0 when out_valid is low)
//   error      some input digit was above 9 (0 when out_valid is low)

module bcd_seq_decoder #(
    parameter int DIGITS = 3,
    parameter int OUT_W  = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  sign,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_W-1:0]      bin_out,
    output logic                  error
);

    // A single-digit build still needs a 1-bit index register.
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        NEG,
        DONE
    } state_t;

    state_t                state;
    state_t                state_n;
    logic [OUT_W-1:0]      acc;
    logic [OUT_W-1:0]      acc_n;
    logic                  err;
    logic                  err_n;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      idx_n;
    logic [4*DIGITS-1:0]   bcd_q;
    logic [4*DIGITS-1:0]   bcd_n;
    logic                  sign_q;
    logic                  sign_n;

    // Current digit selected by shifting the captured word down by 4*idx.
    logic [4*DIGITS-1:0]   bcd_shifted;
    logic [3:0]            digit;

    assign bcd_shifted = bcd_q >> {idx, 2'b00};
    assign digit       = bcd_shifted[3:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            acc    <= '0;
            err    <= 1'b0;
            idx    <= '0;
            bcd_q  <= '0;
            sign_q <= 1'b0;
        end else begin
            state  <= state_n;
            acc    <= acc_n;
            err    <= err_n;
            idx    <= idx_n;
            bcd_q  <= bcd_n;
            sign_q <= sign_n;
        end
    end

    always_comb begin
        state_n   = state;
        acc_n     = acc;
        err_n     = err;
        idx_n     = idx;
        bcd_n     = bcd_q;
        sign_n    = sign_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        bin_out   = '0;
        error     = 1'b0;

        case (state)
            IDLE: begin
                // Held low while reset is asserted so nothing looks accepted.
                in_ready = ~reset;
                if (in_valid) begin
                    bcd_n   = bcd_in;
                    sign_n  = sign;
                    acc_n   = '0;
                    err_n   = 1'b0;
                    idx_n   = IDX_W'(DIGITS - 1);
                    state_n = CONV;
                end
            end

            CONV: begin
                // acc*10 as (acc<<3)+(acc<<1), wrapping at OUT_W bits.
                acc_n = (acc << 3) + (acc << 1) + OUT_W'(digit);
                if (digit > 4'd9) begin
                    err_n = 1'b1;
                end
                if (idx == '0) begin
                    state_n = NEG;
                end else begin
                    idx_n = idx - IDX_W'(1);
                end
            end

            NEG: begin
                if (err) begin
                    acc_n = '0;
                end else if (sign_q && (acc != '0)) begin
                    acc_n = ~acc + OUT_W'(1);
                end
                state_n = DONE;
            end

            DONE: begin
                out_valid = 1'b1;
                bin_out   = acc;
                error     = err;
                if (out_ready) begin
                    state_n = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bcd_seq_decoder.sv
// tb/tb_bcd_seq_decoder.sv - self-checking bench for bcd_seq_decoder (3- and 4-digit builds)

module tb_bcd_seq_decoder;

    logic        clk = 1'b0;
    logic        reset;

    logic        in_valid3;
    logic        in_ready3;
    logic        sign3;
    logic [11:0] bcd3;
    logic        out_valid3;
    logic        out_ready3;
    logic [10:0] bin3;
    logic        error3;

    logic        in_valid4;
    logic        in_ready4;
    logic        sign4;
    logic [15:0] bcd4;
    logic        out_valid4;
    logic        out_ready4;
    logic [14:0] bin4;
    logic        error4;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bcd_seq_decoder #(.DIGITS(3), .OUT_W(11)) dut3 (
        .clk(clk), .reset(reset), .in_valid(in_valid3), .in_ready(in_ready3),
        .sign(sign3), .bcd_in(bcd3), .out_valid(out_valid3), .out_ready(out_ready3),
        .bin_out(bin3), .error(error3)
    );

    bcd_seq_decoder #(.DIGITS(4), .OUT_W(15)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
        .sign(sign4), .bcd_in(bcd4), .out_valid(out_valid4), .out_ready(out_ready4),
        .bin_out(bin4), .error(error4)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Decimal value of the digits, negated if signed, zero if any digit > 9,
    // reduced modulo 2^w.
    task automatic model(input logic s, input logic [15:0] b, input int nd, input int w,
                         output longint v, output logic e);
        longint mag;
        int d;
        mag = 0;
        e   = 1'b0;
        for (int i = nd - 1; i >= 0; i--) begin
            d = int'((b >> (4 * i)) & 16'hF);
            if (d > 9) e = 1'b1;
            mag = mag * 10 + d;
        end
        if (e) v = 0;
        else   v = s ? -mag : mag;
        v = v & ((64'sd1 <<< w) - 1);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One 3-digit conversion: checks latency, result, hold under backpressure
    // (hold cycles with out_ready low and a spurious in_valid), and return to IDLE.
    task automatic run3(input logic s, input logic [11:0] b, input int hold, input string tag);
        longint ev;
        logic   ee;
        int     cyc;
        model(s, {4'h0, b}, 3, 11, ev, ee);
        check({tag, " in_ready idle"}, in_ready3, 1);
        in_valid3  = 1'b1;
        sign3      = s;
        bcd3       = b;
        out_ready3 = (hold == 0);
        tick();
        in_valid3 = 1'b0;
        sign3     = 1'($urandom);
        bcd3      = 12'($urandom);
        cyc = 0;
        while (!out_valid3 && cyc < 20) begin
            if (in_ready3 !== 1'b0) check({tag, " in_ready busy"}, in_ready3, 0);
            tick();
            cyc++;
        end
        check({tag, " latency"}, cyc, 4);
        check({tag, " bin_out"}, bin3, ev[10:0]);
        check({tag, " error"}, error3, ee);
        if (hold > 0) begin
            in_valid3 = 1'b1;
            for (int i = 0; i < hold; i++) begin
                tick();
                check({tag, " held out_valid"}, out_valid3, 1);
                check({tag, " held bin_out"}, bin3, ev[10:0]);
                check({tag, " held error"}, error3, ee);
                check({tag, " held in_ready"}, in_ready3, 0);
            end
            in_valid3  = 1'b0;
            out_ready3 = 1'b1;
        end
        tick();
        check({tag, " out_valid cleared"}, out_valid3, 0);
        check({tag, " in_ready back"}, in_ready3, 1);
    endtask

    task automatic run4(input logic s, input logic [15:0] b, input string tag);
        longint ev;
        logic   ee;
        int     cyc;
        model(s, b, 4, 15, ev, ee);
        in_valid4  = 1'b1;
        sign4      = s;
        bcd4       = b;
        out_ready4 = 1'b1;
        tick();
        in_valid4 = 1'b0;
        bcd4      = 16'($urandom);
        cyc = 0;
        while (!out_valid4 && cyc < 20) begin
            tick();
            cyc++;
        end
        check({tag, " latency"}, cyc, 5);
        check({tag, " bin_out"}, bin4, ev[14:0]);
        check({tag, " error"}, error4, ee);
        tick();
        check({tag, " in_ready back"}, in_ready4, 1);
    endtask

    initial begin
        logic [11:0] rb;
        reset      = 1'b1;
        in_valid3  = 1'b0; sign3 = 1'b0; bcd3 = '0; out_ready3 = 1'b1;
        in_valid4  = 1'b0; sign4 = 1'b0; bcd4 = '0; out_ready4 = 1'b1;

        // Reset state
        tick();
        check("rst in_ready", in_ready3, 0);
        check("rst out_valid", out_valid3, 0);
        check("rst bin_out", bin3, 0);
        check("rst error", error3, 0);
        tick();
        reset = 1'b0;
        check("rst in_ready during", in_ready3, 0);
        tick();
        check("post-rst in_ready", in_ready3, 1);
        check("post-rst in_ready4", in_ready4, 1);

        // Directed cases
        run3(1'b0, 12'h999, 0, "p999");
        run3(1'b1, 12'h999, 0, "n999");
        check("n999 pattern", 11'b10000011001, 11'h419);
        run3(1'b1, 12'h042, 0, "n42");
        run3(1'b1, 12'h000, 0, "negzero");
        run3(1'b0, 12'h1A5, 0, "bad_mid");
        run3(1'b0, 12'h105, 0, "after_bad");
        run3(1'b1, 12'hF00, 2, "bad_msd");
        run3(1'b0, 12'h587, 6, "backpressure");

        // Reset in the middle of a conversion
        in_valid3 = 1'b1; sign3 = 1'b0; bcd3 = 12'h777;
        tick();
        in_valid3 = 1'b0;
        tick();
        reset = 1'b1;
        check("midrst in_ready", in_ready3, 0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid3 !== 1'b0) check("midrst out_valid", out_valid3, 0);
            tick();
        end
        check("midrst quiet out_valid", out_valid3, 0);
        check("midrst in_ready", in_ready3, 1);
        run3(1'b0, 12'h321, 0, "p321");

        // Randomised conversions
        for (int n = 0; n < 25; n++) begin
            rb = 12'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                for (int k = 0; k < 3; k++) rb[4*k +: 4] = 4'($urandom_range(0, 9));
            end
            run3(1'($urandom), rb, int'($urandom_range(0, 3)), "rand3");
        end

        // 4-digit build
        run4(1'b0, 16'h9999, "p9999");
        run4(1'b1, 16'h0001, "n1");
        run4(1'b1, 16'h2B00, "bad4");
        for (int n = 0; n < 10; n++) begin
            logic [15:0] b4;
            for (int k = 0; k < 4; k++) b4[4*k +: 4] = 4'($urandom_range(0, 9));
            run4(1'($urandom), b4, "rand4");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
